mesh_term_injector: RTL and testbench
=====================================

// Module: mesh_term_injector
// PURPOSE
//  Terminal-side injection stage sitting directly upstream of one mesh_gnrtr terminal input port.
//  Accepts packet fields from a terminal producer, assembles the pckg_sz-bit mesh packet and queues it in a FIFO.
//  Presents the queue head on the mesh's pndng_i_in/data_out_i_in pair and retires it on the mesh's popin strobe.
//  Drops illegal or overflow pushes and reports them through a counter and a sticky flag.
// PARAMETERS
//  pckg_sz     40  packet width in bits (>= 26)
//  fifo_depth  4   queue depth in packets (>= 2, power of 2)
//  ROWS        4   mesh rows; legal dest row range 0..ROWS+1
//  COLUMS      4   mesh columns; legal dest col range 0..COLUMS+1
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              synchronous, active-high
//  push          in   1              producer write strobe
//  push_row      in   4              destination row
//  push_col      in   4              destination column
//  push_mode     in   1              routing mode (0 = col-first, 1 = row-first)
//  push_payload  in   pckg_sz-17     payload
//  push_ready    out  1              queue not full (count < fifo_depth)
//  pndng         out  1              head valid; drives mesh pndng_i_in
//  data_out      out  pckg_sz        head packet; drives mesh data_out_i_in
//  popin         in   1              mesh consumed head; from mesh popin
//  count         out  $clog2(fifo_depth+1)  packets queued
//  drop_cnt      out  16             dropped pushes, saturating
//  overflow      out  1              sticky: a push was dropped since reset
// BEHAVIOUR
//  Packet format (MSB..LSB):
//   [pckg_sz-1:pckg_sz-8]   nxt_jump = 8'h00
//   [pckg_sz-9:pckg_sz-12]  push_row
//   [pckg_sz-13:pckg_sz-16] push_col
//   [pckg_sz-17]            push_mode
//   [pckg_sz-18:0]          push_payload
//  Reset (clk edge with reset=1):
//   - count=0, pndng=0, data_out=0, drop_cnt=0, overflow=0, push_ready=1.
//   - Read/write pointers cleared; queued packets discarded.
//   - push/popin ignored that cycle.
//   - Reset mid-operation flushes the queue; no partial packet is ever presented.
//  Push acceptance, evaluated on the clk edge:
//   - push=1 AND count<fifo_depth AND push_row<=ROWS+1 AND push_col<=COLUMS+1 -> packet written at wr_ptr; wr_ptr wraps at fifo_depth.
//   - push=1 AND illegal address (full or not) -> drop: drop_cnt+1 (holds at 16'hFFFF), overflow<=1.
//   - push=1 AND count==fifo_depth (legal address) -> same drop handling.
//   - No bypass: when full, a push is dropped even if popin=1 in the same cycle.
//  Pop:
//   - popin=1 AND count>0 -> rd_ptr advances (wraps).
//   - popin=1 with count==0 -> ignored; no error.
//  Count update:
//   - accepted push & valid pop in the same cycle -> count unchanged; both pointers advance.
//  Outputs:
//   - pndng = (count!=0), registered.
//   - data_out = mem[rd_ptr] while pndng=1; forced 0 when empty.
//   - push_ready = (count<fifo_depth).
//  Latency:
//   - Push accepted at edge N -> pndng=1 and data_out valid after edge N (visible cycle N+1).
//   - popin at edge M -> next head (or pndng=0) visible cycle M+1.
//  Ordering: strict FIFO; packets are never reordered or duplicated.
// TESTING
//  T1 reset; push row=1 col=5 mode=1 payload=0x0ABCDE (pckg_sz=40) -> next cycle pndng=1, data_out=0x00_15_0A_BCDE|mode bit set, count=1.
//  T2 push 5 legal packets back-to-back, no popin -> count=4, push_ready=0, 5th dropped, drop_cnt=1, overflow=1.
//  T3 full queue, push+popin same cycle -> pop occurs, push dropped, count=3, drop_cnt increments.
//  T4 count=2, push+popin same cycle -> count stays 2, FIFO order P1,P2,P3 preserved on data_out.
//  T5 push row=6 (ROWS=4) on empty queue -> not queued, pndng=0, drop_cnt=1; popin on empty -> no change.
//  T6 queue 3 packets, assert reset one cycle -> count=0, pndng=0, data_out=0, drop_cnt=0, overflow=0.

Source files
------------

// File: rtl/mesh_term_injector_if.sv
// Terminal-side injection bus: producer push fields plus the mesh pending/data/pop handshake.
interface mesh_term_injector_if #(
   parameter int unsigned pckg_sz = 40
);
   logic               push;
   logic [3:0]         push_row;
   logic [3:0]         push_col;
   logic               push_mode;
   logic [pckg_sz-18:0] push_payload;
   logic               push_ready;
   logic               pndng;
   logic [pckg_sz-1:0] data_out;
   logic               popin;

   modport master (
      output push, push_row, push_col, push_mode, push_payload, popin,
      input  push_ready, pndng, data_out
   );

   modport slave (
      input  push, push_row, push_col, push_mode, push_payload, popin,
      output push_ready, pndng, data_out
   );
endinterface

// File: rtl/mesh_term_injector.sv
// Assembles terminal packets into a small FIFO and presents the head to one mesh input port.
// Illegal-address or full-queue pushes are dropped and counted.
module mesh_term_injector #(
   parameter int unsigned pckg_sz    = 40,
   parameter int unsigned fifo_depth = 4,
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLUMS     = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   mesh_term_injector_if.slave               bus,
   output logic [$clog2(fifo_depth+1)-1:0]   count,
   output logic [15:0]                       drop_cnt,
   output logic                              overflow
);
   localparam int unsigned CntW = $clog2(fifo_depth + 1);
   localparam int unsigned PtrW = $clog2(fifo_depth);
   localparam logic [3:0]  MaxRow = 4'(ROWS + 1);
   localparam logic [3:0]  MaxCol = 4'(COLUMS + 1);
   localparam logic [CntW-1:0] Full = CntW'(fifo_depth);

   logic [pckg_sz-1:0] mem_q [fifo_depth];
   logic [pckg_sz-1:0] mem_d [fifo_depth];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic               overflow_q, overflow_d;
   logic               pndng_q, pndng_d;
   logic [pckg_sz-1:0] data_out_q, data_out_d;

   logic               addr_ok;
   logic               do_push;
   logic               do_pop;
   logic               drop;
   logic [pckg_sz-1:0] pkt;

   always_comb begin
      addr_ok = (bus.push_row <= MaxRow) && (bus.push_col <= MaxCol);
      // No bypass: fullness is judged on the pre-pop count.
      do_push = bus.push && addr_ok && (count_q != Full);
      do_pop  = bus.popin && (count_q != '0);
      drop    = bus.push && !do_push;
      pkt     = {8'h00, bus.push_row, bus.push_col, bus.push_mode, bus.push_payload};

      mem_d = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = pkt;
      end

      wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntW'(1);
      end

      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end

      // Head is looked up in the post-write image so a push into an empty queue shows next cycle.
      pndng_d    = (count_d != '0);
      data_out_d = pndng_d ? mem_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
         pndng_q    <= 1'b0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
         pndng_q    <= pndng_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= mem_d;
      end
   end

   assign bus.push_ready = (count_q < Full);
   assign bus.pndng      = pndng_q;
   assign bus.data_out   = data_out_q;
   assign count          = count_q;
   assign drop_cnt       = drop_cnt_q;
   assign overflow       = overflow_q;
endmodule

// File: tb/tb_mesh_term_injector.sv
// Scoreboard bench for mesh_term_injector: stimulus queues expected packets, a monitor checks pops.
module tb_mesh_term_injector;
   localparam int unsigned PCKG_SZ = 40;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PW      = PCKG_SZ - 17;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  count;
   logic [15:0] drop_cnt;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   logic [PCKG_SZ-1:0] exp_q [$];

   mesh_term_injector_if #(.pckg_sz(PCKG_SZ)) bus ();

   mesh_term_injector #(
      .pckg_sz   (PCKG_SZ),
      .fifo_depth(DEPTH),
      .ROWS      (4),
      .COLUMS    (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .count   (count),
      .drop_cnt(drop_cnt),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [PCKG_SZ-1:0] mk(input logic [3:0] row, input logic [3:0] col,
                                             input logic mode, input logic [PW-1:0] pl);
      return {8'h00, row, col, mode, pl};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus; acc says whether the bench expects the push to be queued.
   task automatic cyc(input logic p, input logic [3:0] row, input logic [3:0] col,
                      input logic mode, input logic [PW-1:0] pl, input logic pop,
                      input logic acc);
      bus.push         = p;
      bus.push_row     = row;
      bus.push_col     = col;
      bus.push_mode    = mode;
      bus.push_payload = pl;
      bus.popin        = pop;
      if (acc) exp_q.push_back(mk(row, col, mode, pl));
      step();
   endtask

   task automatic idle();
      cyc(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic pop1();
      cyc(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   // Monitor: whenever the mesh consumes a valid head, it must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.popin && bus.pndng) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected: got 0x%0h expected no packet", bus.data_out);
         end else begin
            logic [PCKG_SZ-1:0] e;
            e = exp_q.pop_front();
            if (bus.data_out !== e) begin
               failures++;
               $display("FAIL pop_data: got 0x%0h expected 0x%0h", bus.data_out, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.push = 1'b0; bus.push_row = '0; bus.push_col = '0;
      bus.push_mode = 1'b0; bus.push_payload = '0; bus.popin = 1'b0;
      step(); step();
      reset = 1'b0;

      // T1: reset state and a single packet
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_pndng", 64'(bus.pndng), 64'd0);
      chk("rst_data", 64'(bus.data_out), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_ready", 64'(bus.push_ready), 64'd1);
      cyc(1'b1, 4'd1, 4'd5, 1'b1, 23'h0ABCDE, 1'b0, 1'b1);
      bus.push = 1'b0;
      chk("t1_pndng", 64'(bus.pndng), 64'd1);
      chk("t1_data", 64'(bus.data_out), 64'h00158ABCDE);
      chk("t1_count", 64'(count), 64'd1);
      pop1();
      chk("t1_empty_pndng", 64'(bus.pndng), 64'd0);
      chk("t1_empty_data", 64'(bus.data_out), 64'd0);

      // T2: fill and overflow by one
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 4'(i), 4'(i + 1), i[0], 23'(32'h100 + i), 1'b0, i < 4);
      end
      idle();
      chk("t2_count", 64'(count), 64'd4);
      chk("t2_ready", 64'(bus.push_ready), 64'd0);
      chk("t2_drop", 64'(drop_cnt), 64'd1);
      chk("t2_ovf", 64'(overflow), 64'd1);

      // T3: full, push + pop together -> pop only
      cyc(1'b1, 4'd2, 4'd2, 1'b0, 23'h7777, 1'b1, 1'b0);
      idle();
      chk("t3_count", 64'(count), 64'd3);
      chk("t3_drop", 64'(drop_cnt), 64'd2);
      chk("t3_ready", 64'(bus.push_ready), 64'd1);

      // T4: at count 2, simultaneous push + pop keeps count and order
      pop1();
      chk("t4_pre_count", 64'(count), 64'd2);
      cyc(1'b1, 4'd3, 4'd4, 1'b1, 23'h2AAAA, 1'b1, 1'b1);
      idle();
      chk("t4_count", 64'(count), 64'd2);
      pop1();
      pop1();
      idle();
      chk("t4_drained", 64'(count), 64'd0);
      chk("t4_drop_hold", 64'(drop_cnt), 64'd2);

      // T5: illegal row / col dropped; boundary row/col accepted; pop on empty harmless
      cyc(1'b1, 4'd6, 4'd0, 1'b0, 23'h1, 1'b0, 1'b0);
      idle();
      chk("t5_row_pndng", 64'(bus.pndng), 64'd0);
      chk("t5_row_drop", 64'(drop_cnt), 64'd3);
      cyc(1'b1, 4'd0, 4'd6, 1'b0, 23'h2, 1'b0, 1'b0);
      idle();
      chk("t5_col_drop", 64'(drop_cnt), 64'd4);
      chk("t5_col_count", 64'(count), 64'd0);
      cyc(1'b1, 4'd5, 4'd5, 1'b0, 23'h55555, 1'b0, 1'b1);
      bus.push = 1'b0;
      chk("t5_edge_count", 64'(count), 64'd1);
      pop1();
      pop1();
      idle();
      chk("t5_empty_pop_count", 64'(count), 64'd0);
      chk("t5_empty_pop_drop", 64'(drop_cnt), 64'd4);

      // T6: reset flushes queued packets and statistics
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 4'd1, 4'd1, 1'b0, 23'(32'h300 + i), 1'b0, 1'b0);
      end
      bus.push = 1'b0;
      chk("t6_pre_count", 64'(count), 64'd3);
      reset = 1'b1;
      cyc(1'b1, 4'd1, 4'd1, 1'b0, 23'h3FF, 1'b1, 1'b0);
      reset = 1'b0;
      bus.push = 1'b0; bus.popin = 1'b0;
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_pndng", 64'(bus.pndng), 64'd0);
      chk("t6_data", 64'(bus.data_out), 64'd0);
      chk("t6_drop", 64'(drop_cnt), 64'd0);
      chk("t6_ovf", 64'(overflow), 64'd0);
      chk("t6_ready", 64'(bus.push_ready), 64'd1);
      cyc(1'b1, 4'd4, 4'd3, 1'b1, 23'h13579, 1'b0, 1'b1);
      bus.push = 1'b0;
      chk("t6_post_data", 64'(bus.data_out), 64'(mk(4'd4, 4'd3, 1'b1, 23'h13579)));
      pop1();
      idle();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
